// File: rtl/float64_pkg.sv
// Shared types and constants for the binary64 unpack/normalize datapath.
// Class encodings, field limits and the controller state enum.
package float64_pkg;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    FINITE = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } zclass_t;

  localparam logic [10:0] EXP_MAX      = 11'h7FF;
  localparam int          HIDDEN_BIT   = 62;
  localparam logic [31:0] FLAG_INVALID = 32'd16;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/unpack_float64_normalize_lzc64.sv
// Combinational 64-bit leading-zero counter.
// An all-zero input reports 64.
module lzc64 (
  input  logic [63:0] sig,
  output logic [6:0]  count
);

  always_comb begin
    count = 7'd64;
    for (int i = 0; i < 64; i++) begin
      if (sig[i]) count = 7'(63 - i);
    end
  end

endmodule

// File: rtl/unpack_float64_normalize.sv
// Unpacks a binary64 operand into sign/exponent/significand with
// the leading one at bit 62; subnormals are normalized over NORM cycles.
module unpack_float64_normalize #(
  parameter int          SHIFT_STEP   = 8,
  parameter logic [31:0] FLAG_INVALID = 32'd16
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [63:0] a,
  input  logic [31:0] float_exception_flag_i,
  output logic        zSign,
  output logic [11:0] zExp,
  output logic [63:0] zSig,
  output logic [1:0]  zClass,
  output logic [31:0] float_exception_flag_o,
  output logic        float_exception_flag_o_ap_vld
);

  import float64_pkg::*;

  localparam logic [6:0] STEP = 7'(SHIFT_STEP);

  state_t      state;
  state_t      state_nx;
  logic [63:0] sig_q;
  logic [11:0] exp_q;
  logic        sign_q;
  logic [31:0] flag_q;

  logic [10:0] e;
  logic [51:0] f;
  logic [63:0] f_sig;
  logic [11:0] d_exp;
  logic [63:0] d_sig;
  zclass_t     d_cls;
  logic [31:0] d_flag;
  logic        d_sub;

  logic [6:0]  lz;
  logic [6:0]  lzm1;
  logic [6:0]  k;
  logic [63:0] sh_sig;
  logic [11:0] sh_exp;

  assign e     = a[62:52];
  assign f     = a[51:0];
  assign f_sig = {2'b00, f, 10'b0};

  always_comb begin
    d_exp  = '0;
    d_sig  = '0;
    d_cls  = ZERO;
    d_flag = float_exception_flag_i;
    d_sub  = 1'b0;
    unique case (1'b1)
      (e == 11'd0) && (f == '0): begin
        d_cls = ZERO;
      end
      (e == 11'd0) && (f != '0): begin
        d_sub = 1'b1;
        d_cls = FINITE;
        d_sig = f_sig;
      end
      (e == EXP_MAX) && (f == '0): begin
        d_exp = {1'b0, EXP_MAX};
        d_cls = INF;
      end
      (e == EXP_MAX) && (f != '0): begin
        d_exp = {1'b0, EXP_MAX};
        d_sig = f_sig;
        d_cls = NAN;
        // quiet bit clear marks a signaling NaN
        if (!f[51]) d_flag = float_exception_flag_i | FLAG_INVALID;
      end
      default: begin
        d_exp = {1'b0, e} - 12'd1;
        d_sig = {2'b01, f, 10'b0};
        d_cls = FINITE;
      end
    endcase
  end

  lzc64 u_lzc (
    .sig   (sig_q),
    .count (lz)
  );

  // Never shift past bit 62: lzc-1 bounds the step.
  assign lzm1   = lz - 7'd1;
  assign k      = (lzm1 > STEP) ? STEP : lzm1;
  assign sh_sig = sig_q << k;
  assign sh_exp = exp_q - {5'b0, k};

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (ap_start) state_nx = d_sub ? NORM : DONE;
      NORM: if (sh_sig[HIDDEN_BIT]) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state                  <= IDLE;
      sig_q                  <= '0;
      exp_q                  <= '0;
      sign_q                 <= 1'b0;
      flag_q                 <= '0;
      zSign                  <= 1'b0;
      zExp                   <= '0;
      zSig                   <= '0;
      zClass                 <= '0;
      float_exception_flag_o <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (ap_start) begin
            sig_q  <= d_sig;
            exp_q  <= '0;
            sign_q <= a[63];
            flag_q <= d_flag;
            if (!d_sub) begin
              zSign                  <= a[63];
              zExp                   <= d_exp;
              zSig                   <= d_sig;
              zClass                 <= d_cls;
              float_exception_flag_o <= d_flag;
            end
          end
        end
        NORM: begin
          sig_q <= sh_sig;
          exp_q <= sh_exp;
          if (sh_sig[HIDDEN_BIT]) begin
            zSign                  <= sign_q;
            zExp                   <= sh_exp;
            zSig                   <= sh_sig;
            zClass                 <= FINITE;
            float_exception_flag_o <= flag_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign ap_idle                       = (state == IDLE);
  assign ap_done                       = (state == DONE);
  assign ap_ready                      = (state == DONE);
  assign float_exception_flag_o_ap_vld = (state == DONE);

endmodule

// File: tb/tb_unpack_float64_normalize.sv
// Scoreboard bench for unpack_float64_normalize.
// Reference model computes each expected triple, flags and latency.
module tb_unpack_float64_normalize;

  typedef struct {
    logic        sign;
    logic [11:0] exp;
    logic [63:0] sig;
    logic [1:0]  cls;
    logic [31:0] flag;
    int          lat;
  } exp_t;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [63:0] a;
  logic [31:0] flag_i;
  logic        zSign;
  logic [11:0] zExp;
  logic [63:0] zSig;
  logic [1:0]  zClass;
  logic [31:0] flag_o;
  logic        vld;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   d0;
  exp_t sb[$];
  int   acc_q[$];

  unpack_float64_normalize #(
    .SHIFT_STEP   (8),
    .FLAG_INVALID (32'd16)
  ) dut (
    .ap_clk                        (ap_clk),
    .ap_rst                        (ap_rst),
    .ap_start                      (ap_start),
    .ap_done                       (ap_done),
    .ap_idle                       (ap_idle),
    .ap_ready                      (ap_ready),
    .a                             (a),
    .float_exception_flag_i        (flag_i),
    .zSign                         (zSign),
    .zExp                          (zExp),
    .zSig                          (zSig),
    .zClass                        (zClass),
    .float_exception_flag_o        (flag_o),
    .float_exception_flag_o_ap_vld (vld)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc++;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] op,
                                 input logic [31:0] fl);
    exp_t        r;
    logic [10:0] e;
    logic [51:0] f;
    int          p;
    int          s;
    e = op[62:52];
    f = op[51:0];
    r.sign = op[63];
    r.exp  = '0;
    r.sig  = '0;
    r.cls  = 2'd0;
    r.flag = fl;
    r.lat  = 1;
    if (e == 0 && f == 0) begin
      r.cls = 2'd0;
    end else if (e == 0) begin
      p = 0;
      for (int i = 0; i < 52; i++) if (f[i]) p = i;
      s = 52 - p;
      r.sig = {2'b00, f, 10'b0} << s;
      r.exp = 12'(-s);
      r.cls = 2'd1;
      r.lat = 1 + (s + 7) / 8;
    end else if (e == 11'h7FF) begin
      r.exp = 12'h7FF;
      if (f == 0) begin
        r.cls = 2'd2;
      end else begin
        r.cls = 2'd3;
        r.sig = {2'b00, f, 10'b0};
        if (!f[51]) r.flag = fl | 32'h10;
      end
    end else begin
      r.exp = {1'b0, e} - 12'd1;
      r.sig = {2'b01, f, 10'b0};
      r.cls = 2'd1;
    end
    return r;
  endfunction

  always @(negedge ap_clk) begin
    exp_t x;
    int   t0;
    if (!ap_rst && ap_done) begin
      done_cnt++;
      if (sb.size() == 0 || acc_q.size() == 0) begin
        check("unexpected_done", ap_done, 1'b0);
      end else begin
        x  = sb.pop_front();
        t0 = acc_q.pop_front();
        check("latency", cyc - t0, x.lat);
        check("zSign", zSign, x.sign);
        check("zExp", zExp, x.exp);
        check("zSig", zSig, x.sig);
        check("zClass", zClass, x.cls);
        check("flag_o", flag_o, x.flag);
        check("ap_ready", ap_ready, 1'b1);
        check("vld", vld, 1'b1);
        check("ap_idle_in_done", ap_idle, 1'b0);
      end
    end
  end

  task automatic drive_op(input logic [63:0] op,
                          input logic [31:0] fl,
                          input bit          track);
    int n;
    a        = op;
    flag_i   = fl;
    ap_start = 1'b1;
    n        = 0;
    forever begin
      @(negedge ap_clk);
      if (ap_idle) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", ap_idle, 1'b1);
        return;
      end
    end
    if (track) begin
      sb.push_back(model(op, fl));
      acc_q.push_back(cyc);
    end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge ap_clk);
    check("drain", sb.size(), 0);
    repeat (2) @(posedge ap_clk);
    #1;
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, "_idle"}, ap_idle, 1'b1);
    check({tag, "_done"}, ap_done, 1'b0);
    check({tag, "_vld"}, vld, 1'b0);
    check({tag, "_zSign"}, zSign, 1'b0);
    check({tag, "_zExp"}, zExp, 12'h0);
    check({tag, "_zSig"}, zSig, 64'h0);
    check({tag, "_zClass"}, zClass, 2'd0);
    check({tag, "_flag"}, flag_o, 32'h0);
  endtask

  initial begin
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    a        = '0;
    flag_i   = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    check_zero_state("reset");
    ap_rst = 1'b0;

    drive_op(64'h3FF0000000000000, 32'h0, 1'b1);
    ap_start = 1'b0;
    drain();
    drive_op(64'h0000000000000001, 32'h0, 1'b1);
    ap_start = 1'b0;
    drain();
    drive_op(64'h7FF0000000000001, 32'h1, 1'b1);
    ap_start = 1'b0;
    drain();
    drive_op(64'h8000000000000000, 32'h0, 1'b1);
    ap_start = 1'b0;
    drain();
    drive_op(64'hFFF0000000000000, 32'h0, 1'b1);
    ap_start = 1'b0;
    drain();
    drive_op(64'h0000000000001000, 32'h4, 1'b1);
    ap_start = 1'b0;
    drain();

    d0 = done_cnt;
    drive_op(64'h0000000000000001, 32'h0, 1'b0);
    ap_start = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    check_zero_state("abort");
    repeat (12) @(posedge ap_clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);

    drive_op(64'h3FF0000000000000, 32'h0, 1'b1);
    ap_start = 1'b0;
    drain();

    d0 = done_cnt;
    drive_op(64'h000FFFFFFFFFFFFF, 32'h0, 1'b1);
    drive_op(64'hC000000000000000, 32'h2, 1'b1);
    drive_op(64'h7FF8000000000000, 32'h5, 1'b1);
    ap_start = 1'b0;
    drain();
    check("held_done_count", done_cnt - d0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unpack_float64_normalize.md
Name: unpack_float64_normalize

Overview:
- Unpacks an IEEE-754 binary64 operand into the sign, exponent and significand triple consumed by roundAndPackFloat64_add.
- Subnormal significands are normalized iteratively, a bounded number of bits per cycle.
- Output convention (exact round trip, no rounding): zSig leading one at bit 62; zExp = biased exponent - 1.
- Used in front of add/sub datapaths; uses the same ap_ctrl_hs block-level handshake and exception-flag passthrough as the packers.

Parameters:
- SHIFT_STEP, 8: maximum left-shift applied per NORM cycle (1..16).
- FLAG_INVALID, 16: bit mask ORed into the flag word for a signaling NaN.

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous reset, active-high
- ap_start  in  1  request; sampled only in IDLE
- ap_done  out  1  one-cycle pulse; results valid
- ap_idle  out  1  high in IDLE
- ap_ready  out  1  one-cycle pulse, coincident with ap_done
- a  in  64  binary64 operand; captured on accept
- float_exception_flag_i  in  32  incoming flag word; captured on accept
- zSign  out  1  sign
- zExp  out  12  two's-complement exponent
- zSig  out  64  significand
- zClass  out  2  0=zero, 1=finite nonzero, 2=inf, 3=NaN
- float_exception_flag_o  out  32  updated flag word
- float_exception_flag_o_ap_vld  out  1  pulses with ap_done

Behaviour:
- Reset: FSM goes to IDLE. ap_done, ap_ready and vld are 0. ap_idle is 1. All data outputs are 0. Reset asserted in any state, including mid-NORM, aborts the operation with no done pulse.
- States:
  - IDLE: on ap_start, capture operand and flag word, then go to NORM if the operand is subnormal, else go to DONE.
  - NORM: go to DONE once sig[62]=1.
  - DONE: assert ap_done, ap_ready and vld for exactly one cycle, then return to IDLE.
- ap_start is ignored outside IDLE. If it is held high, the next operand is accepted in the IDLE cycle after DONE (minimum 2 cycles per operand).
- Decode: E=a[62:52], F=a[51:0].
  - E=0, F=0: zExp=0, zSig=0, zClass=0.
  - 0<E<0x7FF: zSig={2'b01,F,10'b0}, zExp=E-1, zClass=1.
  - E=0, F≠0: load sig={2'b00,F,10'b0} and exp=0, zClass=1. Each NORM cycle computes k=min(SHIFT_STEP, lzc(sig)-1), then sig<<=k and exp-=k. The total shift s satisfies 1≤s≤52. Final zExp=-s (12-bit two's complement).
  - E=0x7FF, F=0: zExp=0x7FF, zSig=0, zClass=2.
  - E=0x7FF, F≠0: zExp=0x7FF, zSig={2'b00,F,10'b0}, zClass=3.
- zSign=a[63] in every case.
- Latency from the accepting edge to ap_done high:
  - normal, zero, inf, NaN: 1 cycle.
  - subnormal: 1+ceil(s/SHIFT_STEP) cycles.
- float_exception_flag_o = captured flag_i | (FLAG_INVALID if sNaN, i.e. E=0x7FF, F≠0, F[51]=0).
- Data outputs are registered and hold their values until the next DONE.

Decomposition:
- Shared package float64_pkg holds:
  - class encodings ZERO, FINITE, INF, NAN.
  - constants EXP_MAX=0x7FF, HIDDEN_BIT=62, FLAG_INVALID=16.
  - the FSM state enum.
- One natural sub-module, lzc64: a combinational 64-bit leading-zero counter used by NORM.

Test Plan:
- 1.0, a=0x3FF0000000000000, flag_i=0: ap_done 1 cycle after accept; zSign=0, zExp=0x3FE, zSig=0x4000000000000000, zClass=1, flag_o=0.
- Smallest subnormal, a=0x0000000000000001: 7 NORM cycles, ap_done at cycle 8; zExp=0xFCC (-52), zSig=0x4000000000000000. Feeding the triple to roundAndPackFloat64_add returns 0x0000000000000001.
- sNaN, a=0x7FF0000000000001, flag_i=0x1: zClass=3, zExp=0x7FF, zSig=0x0000000000000400, flag_o=0x11, vld pulses with ap_done.
- -0.0, a=0x8000000000000000: zSign=1, zExp=0, zSig=0, zClass=0. Then -inf, a=0xFFF0000000000000: zClass=2, zExp=0x7FF, zSig=0.
- Reset mid-NORM: assert ap_rst during cycle 3 of the smallest-subnormal case. No ap_done pulse; next cycle ap_idle=1 and outputs are 0. A fresh 1.0 request then completes normally.
- ap_start held high over 3 different operands: one accept per IDLE cycle, ap_done pulses exactly 3 times, and results match each operand in order.
